// File: rtl/cpu_pkg.sv
// Shared CPU constants: functional-unit codes, tag/data widths, TAG_NONE.
// Used by the decoder, reservation stations and the CDB arbiter.
package cpu_pkg;

   // Decoder fununit field; also the CDB requester index.
   typedef enum logic [1:0] {
      FU_BR   = 2'b00,
      FU_ALU  = 2'b01,
      FU_MEM  = 2'b10,
      FU_MULT = 2'b11
   } fununit_e;

   localparam int NUM_FU = 4;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;

   // Tag 0 means "no producer": a request carrying it is never broadcast.
   localparam logic [TAG_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotates the eligible vector so rr_ptr sits at bit 0,
// priority-encodes the lowest set bit, then maps the offset back to a unit index.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     elig,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     pick,
   output logic [PTR_W-1:0] pick_idx,
   output logic             found
);

   logic [N-1:0]     rot;
   logic [PTR_W-1:0] off;
   logic [PTR_W:0]   sum;

   // Rotate via double-width shift, priority-encode, un-rotate with explicit wrap.
   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      rot   = N'({elig, elig} >> rr_ptr);
      found = 1'b0;
      off   = '0;
      // Scan downward so the lowest set bit is the one that sticks.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            found = 1'b1;
            off   = PTR_W'(k);
         end
      end
      // NUM_UNITS need not be a power of two, so wrap by subtraction, not truncation.
      sum = {1'b0, off} + {1'b0, rr_ptr};
      if (sum >= (PTR_W + 1)'(N)) begin
         sum = sum - (PTR_W + 1)'(N);
      end
      pick_idx = sum[PTR_W-1:0];
      pick     = '0;
      if (found) begin
         pick[pick_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one eligible functional unit per cycle in
// round-robin order and registers the winner's result onto the CDB.
module cdb_arbiter #(
   parameter int NUM_UNITS = cpu_pkg::NUM_FU,
   parameter int TAG_W     = cpu_pkg::TAG_W,
   parameter int DATA_W    = cpu_pkg::DATA_W,
   parameter int CNT_W     = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [NUM_UNITS-1:0]        req,
   input  logic [NUM_UNITS*TAG_W-1:0]  req_tag,
   input  logic [NUM_UNITS*DATA_W-1:0] req_data,
   input  logic [NUM_UNITS-1:0]        req_ov,
   output logic [NUM_UNITS-1:0]        gnt,
   output logic                        cdb_valid,
   output logic [TAG_W-1:0]            cdb_tag,
   output logic [DATA_W-1:0]           cdb_data,
   output logic                        cdb_ov,
   output logic [CNT_W-1:0]            bcast_cnt
);
   import cpu_pkg::*;

   localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [PTR_W-1:0]     rr_ptr;
   logic [NUM_UNITS-1:0] elig;
   logic [NUM_UNITS-1:0] pick;
   logic [PTR_W-1:0]     pick_idx;
   logic                 found;
   logic                 grant_en;
   logic [TAG_W-1:0]     sel_tag;
   logic [DATA_W-1:0]    sel_data;
   logic                 sel_ov;

   // A unit is eligible only if it requests with a real producer tag.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         elig[i] = req[i] && (req_tag[i*TAG_W +: TAG_W] != TAG_W'(TAG_NONE));
      end
   end

   rr_pick #(
      .N     (NUM_UNITS),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .elig     (elig),
      .rr_ptr   (rr_ptr),
      .pick     (pick),
      .pick_idx (pick_idx),
      .found    (found)
   );

   // Grant is suppressed during reset and flush; otherwise the picker's winner.
   always_comb begin
      grant_en = found && !flush && !reset;
      gnt      = grant_en ? pick : '0;
      sel_tag  = req_tag[pick_idx*TAG_W +: TAG_W];
      sel_data = req_data[pick_idx*DATA_W +: DATA_W];
      sel_ov   = req_ov[pick_idx];
   end

   // Pointer, CDB broadcast registers and saturating broadcast counter.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_ov    <= 1'b0;
         bcast_cnt <= '0;
      end else begin
         cdb_valid <= grant_en;
         if (grant_en) begin
            cdb_tag  <= sel_tag;
            cdb_data <= sel_data;
            cdb_ov   <= sel_ov;
            rr_ptr   <= (pick_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : pick_idx + 1'b1;
            if (bcast_cnt != '1) begin
               bcast_cnt <= bcast_cnt + 1'b1;
            end
         end
      end
   end

endmodule
